pipe_stage_reg: RTL and testbench

- Parametrised, handshaked pipeline stage register carrying pc, instruction, result data, destination register and write-enable between two CPU pipeline stages.
- Generalised successor of the fixed-width always-load stage registers.
- Adds valid/ready flow control, flush, an optional 2-entry skid buffer and a saturating bubble counter.
- Sits between any two pipeline stages, e.g. MEM->WB, where the downstream stage can stall.

---
 rtl/pipe_stage_reg.sv | 163 ++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg
//  Description : Handshaked pipeline stage register (pc, ins, data, rd, gwe)
//                with flush, optional 2-entry skid buffer and a saturating
//                bubble counter.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_stage_reg #(
  parameter int          DATA_W   = 32,
  parameter int          REG_W    = 5,
  parameter logic [31:0] PC_RESET = 32'h3000,
  parameter int          SKID     = 1,
  parameter int          CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              I_valid,
  output logic              O_ready,
  input  logic [31:0]       I_pc,
  input  logic [31:0]       I_ins,
  input  logic [DATA_W-1:0] I_data,
  input  logic [REG_W-1:0]  I_rd,
  input  logic              I_gwe,
  output logic              O_valid,
  input  logic              I_ready,
  output logic [31:0]       O_pc,
  output logic [31:0]       O_ins,
  output logic [DATA_W-1:0] O_data,
  output logic [REG_W-1:0]  O_rd,
  output logic              O_gwe,
  output logic [CNT_W-1:0]  O_bubble_cnt
);

  typedef struct packed {
    logic [31:0]       pc;
    logic [31:0]       ins;
    logic [DATA_W-1:0] data;
    logic [REG_W-1:0]  rd;
    logic              gwe;
  } entry_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  localparam entry_t           C_EMPTY   = {PC_RESET, 32'd0, {DATA_W{1'b0}}, {REG_W{1'b0}}, 1'b0};
  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  state_t           r_state;
  state_t           w_state_nxt;
  entry_t           r_main;
  entry_t           r_skid;
  entry_t           w_in;
  logic [CNT_W-1:0] r_bubble_cnt;
  logic             w_valid;
  logic             w_ready;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic             w_main_ld_in;
  logic             w_main_ld_skid;
  logic             w_skid_ld_in;

  assign w_in       = {I_pc, I_ins, I_data, I_rd, I_gwe};
  assign w_valid    = (r_state != S_EMPTY);
  assign w_in_xfer  = I_valid & w_ready;
  assign w_out_xfer = w_valid & I_ready;

  generate
    if (SKID != 0) begin : g_skid
      // Ready comes from registered state only, breaking the I_ready path.
      assign w_ready = (r_state != S_TWO);
    end else begin : g_no_skid
      // Single entry: accept when empty or when the head leaves this cycle.
      assign w_ready = !w_valid | I_ready;
    end
  endgenerate

  // Next-state and entry-load decode from the two transfer strobes.
  always_comb begin
    w_state_nxt    = r_state;
    w_main_ld_in   = 1'b0;
    w_main_ld_skid = 1'b0;
    w_skid_ld_in   = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_in_xfer) begin
          w_state_nxt  = S_ONE;
          w_main_ld_in = 1'b1;
        end
      end
      S_ONE: begin
        if (w_in_xfer && w_out_xfer) begin
          w_main_ld_in = 1'b1;
        end else if (w_in_xfer) begin
          w_state_nxt  = S_TWO;
          w_skid_ld_in = 1'b1;
        end else if (w_out_xfer) begin
          w_state_nxt  = S_EMPTY;
        end
      end
      S_TWO: begin
        if (w_out_xfer) begin
          w_state_nxt    = S_ONE;
          w_main_ld_skid = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_EMPTY;
      end
    endcase
  end

  // State register; flush empties the stage and drops any same-cycle beat.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Entry storage; an emptied head keeps its last contents until reloaded.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_main <= C_EMPTY;
      r_skid <= C_EMPTY;
    end else begin
      if (w_main_ld_in) begin
        r_main <= w_in;
      end else if (w_main_ld_skid) begin
        r_main <= r_skid;
      end
      if (w_skid_ld_in) begin
        r_skid <= w_in;
      end
    end
  end

  // Saturating count of cycles without a valid head; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bubble_cnt <= '0;
    end else if (!w_valid && (r_bubble_cnt != C_CNT_MAX)) begin
      r_bubble_cnt <= r_bubble_cnt + C_CNT_ONE;
    end
  end

  assign O_ready      = w_ready;
  assign O_valid      = w_valid;
  assign O_pc         = r_main.pc;
  assign O_ins        = w_valid ? r_main.ins : 32'd0;
  assign O_data       = r_main.data;
  assign O_rd         = r_main.rd;
  assign O_gwe        = r_main.gwe & w_valid;
  assign O_bubble_cnt = r_bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_reg
//  Description : Self-checking bench for pipe_stage_reg. Two instances share
//                stimulus: one with skid buffer and wide counter, one single
//                entry with a 2-bit counter. Each is compared against a
//                FIFO-style reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        gwe;
  } pkt_t;

  logic        clk = 1'b0;
  logic        reset, flush, i_valid, i_ready;
  logic [31:0] i_pc, i_ins, i_data;
  logic [4:0]  i_rd;
  logic        i_gwe;

  logic        ready0, valid0, gwe0;
  logic [31:0] pc0, ins0, data0;
  logic [4:0]  rd0;
  logic [15:0] cnt0;
  logic        ready1, valid1, gwe1;
  logic [31:0] pc1, ins1, data1;
  logic [4:0]  rd1;
  logic [1:0]  cnt1;

  int nvec = 0;
  int nerr = 0;

  // Reference model: per instance a FIFO of held beats plus the last head.
  pkt_t mq   [2][2];
  int   mc   [2];
  pkt_t mlast[2];
  int   mbub [2];
  int   mcap [2] = '{65535, 3};

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(32), .REG_W(5), .PC_RESET(32'h3000), .SKID(1), .CNT_W(16)) u_dut0 (
    .clk(clk), .reset(reset), .flush(flush), .I_valid(i_valid), .O_ready(ready0),
    .I_pc(i_pc), .I_ins(i_ins), .I_data(i_data), .I_rd(i_rd), .I_gwe(i_gwe),
    .O_valid(valid0), .I_ready(i_ready), .O_pc(pc0), .O_ins(ins0), .O_data(data0),
    .O_rd(rd0), .O_gwe(gwe0), .O_bubble_cnt(cnt0)
  );

  pipe_stage_reg #(.DATA_W(32), .REG_W(5), .PC_RESET(32'h3000), .SKID(0), .CNT_W(2)) u_dut1 (
    .clk(clk), .reset(reset), .flush(flush), .I_valid(i_valid), .O_ready(ready1),
    .I_pc(i_pc), .I_ins(i_ins), .I_data(i_data), .I_rd(i_rd), .I_gwe(i_gwe),
    .O_valid(valid1), .I_ready(i_ready), .O_pc(pc1), .O_ins(ins1), .O_data(data1),
    .O_rd(rd1), .O_gwe(gwe1), .O_bubble_cnt(cnt1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic pkt_t empty_pkt();
    pkt_t p;
    p     = '0;
    p.pc  = 32'h3000;
    return p;
  endfunction

  task automatic chk_dut(input int d);
    pkt_t h;
    bit   v;
    v = (mc[d] > 0);
    h = v ? mq[d][0] : mlast[d];
    if (d == 0) begin
      chk("d0_valid", valid0, v);
      chk("d0_pc",    pc0,    h.pc);
      chk("d0_ins",   ins0,   v ? h.ins : 32'd0);
      chk("d0_data",  data0,  h.data);
      chk("d0_rd",    rd0,    h.rd);
      chk("d0_gwe",   gwe0,   h.gwe & v);
      chk("d0_cnt",   cnt0,   mbub[0]);
    end else begin
      chk("d1_valid", valid1, v);
      chk("d1_pc",    pc1,    h.pc);
      chk("d1_ins",   ins1,   v ? h.ins : 32'd0);
      chk("d1_data",  data1,  h.data);
      chk("d1_rd",    rd1,    h.rd);
      chk("d1_gwe",   gwe1,   h.gwe & v);
      chk("d1_cnt",   cnt1,   mbub[1]);
    end
  endtask

  // One clock: check ready before the edge, advance model, check outputs after.
  task automatic step();
    bit   rdy [2];
    bit   inx, outx;
    pkt_t pin;
    #1;
    rdy[0] = (mc[0] < 2);
    rdy[1] = (mc[1] == 0) || i_ready;
    if (!reset) begin
      chk("d0_ready", ready0, rdy[0]);
      chk("d1_ready", ready1, rdy[1]);
    end
    pin = '{pc: i_pc, ins: i_ins, data: i_data, rd: i_rd, gwe: i_gwe};
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      inx  = i_valid && rdy[d];
      outx = (mc[d] > 0) && i_ready;
      if (reset) begin
        mc[d]    = 0;
        mlast[d] = empty_pkt();
        mbub[d]  = 0;
      end else begin
        if (mc[d] == 0 && mbub[d] < mcap[d]) mbub[d]++;
        if (flush) begin
          mc[d]    = 0;
          mlast[d] = empty_pkt();
        end else begin
          if (outx) begin
            mlast[d]    = mq[d][0];
            mq[d][0]    = mq[d][1];
            mc[d]--;
          end
          if (inx) begin
            mq[d][mc[d]] = pin;
            mc[d]++;
          end
        end
      end
    end
    #1;
    chk_dut(0);
    chk_dut(1);
  endtask

  task automatic set_beat(input logic [31:0] pc, input logic [31:0] ins,
                          input logic [4:0] rd, input logic gwe);
    i_valid = 1'b1;
    i_pc    = pc;
    i_ins   = ins;
    i_data  = ins ^ 32'h5A5A_0000;
    i_rd    = rd;
    i_gwe   = gwe;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    i_pc = '0; i_ins = '0; i_data = '0; i_rd = '0; i_gwe = 1'b0;
    for (int d = 0; d < 2; d++) begin
      mc[d] = 0; mlast[d] = empty_pkt(); mbub[d] = 0;
      mq[d][0] = empty_pkt(); mq[d][1] = empty_pkt();
    end
    @(posedge clk); #1;

    // Reset, then five idle cycles.
    step();
    chk("rst_ready0", ready0, 1'b1);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("idle_pc",   pc0,  32'h3000);
    chk("idle_cnt",  cnt0, 16'd5);
    chk("sat_cnt",   cnt1, 2'd3);

    // Back-to-back streaming.
    set_beat(32'h3000, 32'hA, 5'd1, 1'b1); step();
    chk("stream_a",  pc0, 32'h3000);
    set_beat(32'h3004, 32'hB, 5'd2, 1'b1); step();
    chk("stream_b",  pc0, 32'h3004);
    set_beat(32'h3008, 32'hC, 5'd3, 1'b0); step();
    chk("stream_c",  ins0, 32'hC);
    i_valid = 1'b0; step();

    // Stall into skid.
    i_ready = 1'b0;
    set_beat(32'h3010, 32'h11, 5'd4, 1'b1); step();
    set_beat(32'h3014, 32'h22, 5'd6, 1'b1); step();
    chk("stall_full", ready0, 1'b0);
    i_valid = 1'b0; step(); step();
    chk("stall_hold", pc0, 32'h3010);
    i_ready = 1'b1; step();
    chk("skid_y", pc0, 32'h3014);
    step();

    // Flush while holding two entries, with a beat offered in the flush cycle.
    i_ready = 1'b0;
    set_beat(32'h3020, 32'h33, 5'd7, 1'b1); step();
    set_beat(32'h3024, 32'h44, 5'd8, 1'b1); step();
    set_beat(32'h3028, 32'h55, 5'd9, 1'b1); flush = 1'b1; step();
    flush = 1'b0; i_valid = 1'b0;
    chk("flush_valid", valid0, 1'b0);
    chk("flush_pc",    pc0,    32'h3000);
    chk("flush_gwe",   gwe0,   1'b0);
    i_ready = 1'b1; step(); step();

    // Write-enable gating after the head drains.
    set_beat(32'h3030, 32'h66, 5'd5, 1'b1); step();
    i_valid = 1'b0; step();
    chk("gate_gwe", gwe0, 1'b0);
    chk("gate_ins", ins0, 32'd0);
    chk("gate_rd",  rd0,  5'd5);

    // Saturated counter survives flush, clears on reset.
    for (int i = 0; i < 4; i++) step();
    flush = 1'b1; step(); flush = 1'b0;
    chk("sat_flush", cnt1, 2'd3);
    reset = 1'b1; step(); reset = 1'b0;
    chk("sat_reset", cnt1, 2'd0);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      i_valid = ($urandom_range(0, 3) != 0);
      i_ready = ($urandom_range(0, 2) != 0);
      i_pc    = $urandom;
      i_ins   = $urandom;
      i_data  = $urandom;
      i_rd    = 5'($urandom_range(0, 31));
      i_gwe   = 1'($urandom_range(0, 1));
      flush   = ($urandom_range(0, 24) == 0);
      reset   = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 1'b0; flush = 1'b0; i_valid = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
